signed_accumulator_mc: RTL and testbench

Parametrised, multi-channel signed accumulator for the batch-options DSP regression set. Accepts a stream of signed samples tagged with a channel index and an add/subtract mode, and keeps one independent running sum per channel in a register array. Supports per-sample clear-and-load, optional saturation and sticky per-channel overflow flags. Also provides an update output stream plus a random-access read port for result checking.

---
 rtl/signed_accumulator_mc_pkg.sv | 29 ++
 rtl/signed_accumulator_mc_accum_alu.sv | 33 +++
 rtl/signed_accumulator_mc.sv | 102 ++++++++++
 tb/tb_signed_accumulator_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/signed_accumulator_mc_pkg.sv
// signed_accumulator_mc_pkg: shared widths, limits and the stage-1 sample record
package signed_accumulator_mc_pkg;

   localparam int CH_MAX_W   = 6;
   localparam int DATA_MAX_W = 64;
   localparam int LIMIT_W    = 128;

   typedef struct packed {
      logic [CH_MAX_W-1:0]          ch;
      logic signed [DATA_MAX_W-1:0] data;
      logic                         sub;
      logic                         clear;
   } s1_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [LIMIT_W-1:0] acc_max(input int w);
      logic [LIMIT_W-1:0] one;
      one = LIMIT_W'(1);
      return signed'((one << (w - 1)) - one);
   endfunction

   function automatic logic signed [LIMIT_W-1:0] acc_min(input int w);
      return ~acc_max(w);
   endfunction

endpackage

// File: rtl/signed_accumulator_mc_accum_alu.sv
// accum_alu: one accumulate/load step at ACC_W+1 bits with overflow detect and optional clamp
module accum_alu
   import signed_accumulator_mc_pkg::*;
#(
   parameter int DATA_W   = 20,
   parameter int ACC_W    = 38,
   parameter int SATURATE = 0
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] data,
   input  logic                     sub,
   input  logic                     clear,
   output logic signed [ACC_W-1:0]  result,
   output logic                     ovf_pos,
   output logic                     ovf_neg
);
   localparam int RW = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

   logic signed [RW-1:0] data_x, base, sum;

   always_comb begin
      data_x  = RW'(data);
      base    = clear ? '0 : RW'(acc);
      sum     = sub ? base - data_x : base + data_x;
      ovf_pos = ~sum[RW-1] & sum[RW-2];
      ovf_neg = sum[RW-1] & ~sum[RW-2];
      result  = (SATURATE != 0 && ovf_pos) ? SAT_MAX :
                (SATURATE != 0 && ovf_neg) ? SAT_MIN : sum[ACC_W-1:0];
   end

endmodule

// File: rtl/signed_accumulator_mc.sv
// signed_accumulator_mc: two-stage multi-channel signed accumulator with sticky overflow and read port
module signed_accumulator_mc
   import signed_accumulator_mc_pkg::*;
#(
   parameter int  DATA_W   = 20,
   parameter int  ACC_W    = 38,
   parameter int  NUM_CH   = 4,
   parameter int  SATURATE = 0,
   localparam int CH_W     = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_sub,
   input  logic                     in_clear,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [ACC_W-1:0]  out_acc,
   input  logic [CH_W-1:0]          rd_ch,
   output logic signed [ACC_W-1:0]  rd_acc,
   output logic [NUM_CH-1:0]        ovf
);
   s1_t                      s1_q, s1_d;
   logic                     s1_valid_q, s1_valid_d;
   logic signed [ACC_W-1:0]  acc_q [NUM_CH];
   logic signed [ACC_W-1:0]  acc_d [NUM_CH];
   logic [NUM_CH-1:0]        ovf_q, ovf_d;
   logic                     out_valid_q;
   logic [CH_W-1:0]          out_ch_q, out_ch_d;
   logic signed [ACC_W-1:0]  out_acc_q, out_acc_d;
   logic signed [ACC_W-1:0]  rd_acc_q, rd_acc_d;
   logic [CH_W-1:0]          s1_ch;
   logic signed [DATA_W-1:0] s1_data;
   logic signed [ACC_W-1:0]  alu_result;
   logic                     alu_ovf_pos, alu_ovf_neg;
   logic                     unused_s1;

   // the shared record is sized for the widest build; only the low bits matter here
   assign s1_ch     = s1_q.ch[CH_W-1:0];
   assign s1_data   = s1_q.data[DATA_W-1:0];
   assign unused_s1 = ^{s1_q.ch, s1_q.data};

   accum_alu #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
   ) u_alu (
      .acc     (acc_q[s1_ch]),
      .data    (s1_data),
      .sub     (s1_q.sub),
      .clear   (s1_q.clear),
      .result  (alu_result),
      .ovf_pos (alu_ovf_pos),
      .ovf_neg (alu_ovf_neg)
   );

   always_comb begin
      s1_valid_d = in_valid && (32'(in_ch) < NUM_CH);
      s1_d       = s1_valid_d ? '{ch: CH_MAX_W'(in_ch), data: DATA_MAX_W'(in_data),
                                  sub: in_sub, clear: in_clear} : s1_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      out_ch_d   = s1_valid_q ? s1_ch : out_ch_q;
      out_acc_d  = s1_valid_q ? alu_result : out_acc_q;
      if (s1_valid_q) begin
         acc_d[s1_ch] = alu_result;
         ovf_d[s1_ch] = !s1_q.clear && (ovf_q[s1_ch] || alu_ovf_pos || alu_ovf_neg);
      end
      rd_acc_d   = (32'(rd_ch) < NUM_CH) ? acc_q[rd_ch] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         acc_q       <= '{default: '0};
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_acc_q   <= '0;
         rd_acc_q    <= '0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid_q <= s1_valid_q;
         out_ch_q    <= out_ch_d;
         out_acc_q   <= out_acc_d;
         rd_acc_q    <= rd_acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_acc   = out_acc_q;
   assign rd_acc    = rd_acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_accumulator_mc.sv
// tb_signed_accumulator_mc: four parameter builds driven in lockstep against an arithmetic reference model
module tb_signed_accumulator_mc;
   localparam int NI = 4;

   int aw  [NI] = '{38, 22, 22, 38};
   int sat [NI] = '{0, 1, 0, 0};
   int ncx [NI] = '{4, 4, 4, 3};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic [1:0] in_ch = '0;
   logic signed [19:0] in_data = '0;
   logic in_sub = 1'b0;
   logic in_clear = 1'b0;
   logic [1:0] rd_ch = '0;

   logic ov0, ov1, ov2, ov3;
   logic [1:0] och0, och1, och2, och3;
   logic signed [37:0] oacc0, oacc3, racc0, racc3;
   logic signed [21:0] oacc1, oacc2, racc1, racc2;
   logic [3:0] ovf0, ovf1, ovf2;
   logic [2:0] ovf3;

   logic ov_a [NI];
   logic [1:0] och_a [NI];
   logic signed [63:0] oacc_a [NI];
   logic signed [63:0] racc_a [NI];
   logic [3:0] ovf_a [NI];

   assign ov_a[0] = ov0;  assign ov_a[1] = ov1;  assign ov_a[2] = ov2;  assign ov_a[3] = ov3;
   assign och_a[0] = och0; assign och_a[1] = och1; assign och_a[2] = och2; assign och_a[3] = och3;
   assign oacc_a[0] = 64'(oacc0); assign oacc_a[1] = 64'(oacc1);
   assign oacc_a[2] = 64'(oacc2); assign oacc_a[3] = 64'(oacc3);
   assign racc_a[0] = 64'(racc0); assign racc_a[1] = 64'(racc1);
   assign racc_a[2] = 64'(racc2); assign racc_a[3] = 64'(racc3);
   assign ovf_a[0] = ovf0; assign ovf_a[1] = ovf1; assign ovf_a[2] = ovf2; assign ovf_a[3] = {1'b0, ovf3};

   signed_accumulator_mc #(.DATA_W(20), .ACC_W(38), .NUM_CH(4), .SATURATE(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .in_sub(in_sub), .in_clear(in_clear), .out_valid(ov0), .out_ch(och0), .out_acc(oacc0),
      .rd_ch(rd_ch), .rd_acc(racc0), .ovf(ovf0));
   signed_accumulator_mc #(.DATA_W(20), .ACC_W(22), .NUM_CH(4), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .in_sub(in_sub), .in_clear(in_clear), .out_valid(ov1), .out_ch(och1), .out_acc(oacc1),
      .rd_ch(rd_ch), .rd_acc(racc1), .ovf(ovf1));
   signed_accumulator_mc #(.DATA_W(20), .ACC_W(22), .NUM_CH(4), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .in_sub(in_sub), .in_clear(in_clear), .out_valid(ov2), .out_ch(och2), .out_acc(oacc2),
      .rd_ch(rd_ch), .rd_acc(racc2), .ovf(ovf2));
   signed_accumulator_mc #(.DATA_W(20), .ACC_W(38), .NUM_CH(3), .SATURATE(0)) dut_ch3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .in_sub(in_sub), .in_clear(in_clear), .out_valid(ov3), .out_ch(och3), .out_acc(oacc3),
      .rd_ch(rd_ch), .rd_acc(racc3), .ovf(ovf3));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   longint m_acc [NI][4];
   bit     m_ovf [NI][4];

   int            q_due [$];
   int            q_ch  [$];
   logic [NI-1:0] q_vld [$];
   longint        q_acc [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // exact sum, then clamp or fold back into the ACC_W two's-complement range
   function automatic longint model_step(input int i, input longint acc, input longint d,
                                         input bit sub, input bit clr, output bit ov);
      longint mx, mn, v;
      mx = (longint'(1) <<< (aw[i] - 1)) - 1;
      mn = -mx - 1;
      v  = (clr ? 64'sd0 : acc) + (sub ? -d : d);
      ov = (v > mx) || (v < mn);
      if (ov) v = (sat[i] != 0) ? ((v > mx) ? mx : mn) : (((v - mn) & ((mx <<< 1) | 1)) + mn);
      return v;
   endfunction

   task automatic send(input int ch, input longint d, input bit sub, input bit clr);
      bit ov;
      logic [NI-1:0] vld;
      in_valid = 1'b1; in_ch = 2'(ch); in_data = 20'(d); in_sub = sub; in_clear = clr;
      for (int i = 0; i < NI; i++) begin
         vld[i] = ch < ncx[i];
         if (vld[i]) begin
            m_acc[i][ch] = model_step(i, m_acc[i][ch], d, sub, clr, ov);
            m_ovf[i][ch] = !clr && (m_ovf[i][ch] || ov);
         end
         q_acc.push_back(m_acc[i][ch]);
      end
      q_due.push_back(cyc + 2);
      q_ch.push_back(ch);
      q_vld.push_back(vld);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic read_ch(input int c);
      rd_ch = 2'(c);
      @(negedge clk);
   endtask

   task automatic check_state();
      idle(3);
      for (int c = 0; c < 4; c++) begin
         read_ch(c);
         for (int i = 0; i < NI; i++)
            chk($sformatf("rd_acc[%0d][%0d]", i, c), racc_a[i], (c < ncx[i]) ? m_acc[i][c] : 64'sd0);
      end
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < ncx[i]; c++)
            chk($sformatf("ovf[%0d][%0d]", i, c), 64'(ovf_a[i][c]), 64'(m_ovf[i][c]));
   endtask

   logic [NI-1:0] mv;
   int mc;
   longint ma;

   always @(negedge clk) begin
      if (mon_en) begin
         if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            mv = q_vld.pop_front();
            mc = q_ch.pop_front();
            for (int i = 0; i < NI; i++) begin
               ma = q_acc.pop_front();
               chk($sformatf("out_valid[%0d]", i), 64'(ov_a[i]), 64'(mv[i]));
               if (mv[i]) begin
                  chk($sformatf("out_ch[%0d]", i), 64'(och_a[i]), 64'(mc));
                  chk($sformatf("out_acc[%0d]", i), oacc_a[i], ma);
               end
            end
         end else begin
            for (int i = 0; i < NI; i++) chk($sformatf("out_valid_idle[%0d]", i), 64'(ov_a[i]), 64'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [19:0] r;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_out_acc[%0d]", i), oacc_a[i], 64'sd0);
         chk($sformatf("rst_ovf[%0d]", i), 64'(ovf_a[i]), 64'd0);
      end
      reset = 1'b0;
      check_state();

      send(0, 5, 0, 0); send(0, 7, 0, 0); send(0, 3, 1, 0);
      for (int k = 0; k < 4; k++) begin
         send(1, 100, 0, 0);
         send(2, 40, 1, 0);
      end
      check_state();
      read_ch(1); chk("acc1_400", racc_a[0], 64'sd400);
      read_ch(2); chk("acc2_m160", racc_a[0], -64'sd160);
      read_ch(0); chk("acc0_9", racc_a[0], 64'sd9);

      send(3, 524287, 0, 1);
      repeat (4) send(3, 524287, 0, 0);
      idle(3);
      read_ch(3);
      chk("sat_clamp", racc_a[1], 64'sd2097151);
      chk("wrap_neg", racc_a[2], -64'sd1572869);
      chk("sat_ovf3", 64'(ovf_a[1][3]), 64'd1);
      chk("wrap_ovf3", 64'(ovf_a[2][3]), 64'd1);
      send(3, 1, 0, 0);
      idle(3);
      read_ch(3);
      chk("wrap_small_add", racc_a[2], -64'sd1572868);
      chk("wrap_ovf_sticky", 64'(ovf_a[2][3]), 64'd1);
      send(3, 1, 0, 1);
      idle(3);
      read_ch(3);
      chk("sat_clear_load", racc_a[1], 64'sd1);
      chk("sat_clear_ovf", 64'(ovf_a[1][3]), 64'd0);
      chk("wrap_clear_ovf", 64'(ovf_a[2][3]), 64'd0);

      send(3, 77, 0, 0);
      send(0, -524288, 1, 0);
      check_state();
      read_ch(0); chk("sub_min_exact", racc_a[0], 64'sd524297);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            r = 20'($urandom);
            send(int'($urandom_range(0, 3)), longint'(r), 1'($urandom), $urandom_range(0, 15) == 0);
         end else idle(1);
      end
      check_state();

      send(1, 55, 0, 0);
      reset = 1'b1;
      in_valid = 1'b1; in_ch = 2'd2; in_data = 20'sd99;
      q_due.delete(); q_ch.delete(); q_vld.delete(); q_acc.delete();
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < 4; c++) begin
            m_acc[i][c] = 0;
            m_ovf[i][c] = 1'b0;
         end
      @(negedge clk);
      reset = 1'b0;
      check_state();
      send(2, 11, 0, 0);
      check_state();

      idle(3);
      chk("queue_drain", 64'(q_due.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
